// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
//   Bundles every signal the fetch stage exchanges with its neighbours:
//   the 8-bit instruction memory port, the branch predictor lookup, the EX
//   redirect and the IF->ID instruction handshake.
//
//   master modport : the fetch unit
//   slave  modport : memory / predictor / EX / ID side
//
//   Signals
//     mem_req          fetch -> mem   byte read request, held until mem_valid
//     mem_addr  [31:0] fetch -> mem   byte address of the current request
//     mem_valid        mem -> fetch   requested byte is on mem_data this cycle
//     mem_data  [7:0]  mem -> fetch   returned byte
//     pred_idx  [W-1:0]fetch -> pred  predictor index = pc[W+1:2]
//     pred_taken       pred -> fetch  taken bit, combinational from pred_idx
//     redirect         EX -> fetch    mispredict, restart at redirect_pc
//     redirect_pc[31:0]EX -> fetch    corrected PC
//     stall            ID -> fetch    ID cannot accept this cycle
//     inst_valid       fetch -> ID    instruction offered
//     inst      [31:0] fetch -> ID    instruction word
//     inst_pc   [31:0] fetch -> ID    PC of inst
//     inst_pred_taken  fetch -> ID    fetch chose a taken target for inst
//
//   Handshake: an instruction moves to ID on a cycle where inst_valid=1 and
//   stall=0; while stall=1 every inst_* signal holds. A cycle with redirect=1
//   voids any transfer in that same cycle, so ID ignores inst_valid then.
// ----------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int PRED_IDX_W = 8
);
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_valid;
    logic [7:0]            mem_data;
    logic [PRED_IDX_W-1:0] pred_idx;
    logic                  pred_taken;
    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic                  stall;
    logic                  inst_valid;
    logic [31:0]           inst;
    logic [31:0]           inst_pc;
    logic                  inst_pred_taken;

    modport master (
        output mem_req, mem_addr, pred_idx,
        output inst_valid, inst, inst_pc, inst_pred_taken,
        input  mem_valid, mem_data, pred_taken,
        input  redirect, redirect_pc, stall
    );

    modport slave (
        input  mem_req, mem_addr, pred_idx,
        input  inst_valid, inst, inst_pc, inst_pred_taken,
        output mem_valid, mem_data, pred_taken,
        output redirect, redirect_pc, stall
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Owns the PC, assembles one 32-bit instruction
//   from four little-endian byte reads, picks the next PC (using the 2-bit
//   predictor's taken bit for conditional branches) and offers
//   {inst, pc, predicted-taken} to ID. An EX redirect restarts fetch.
//
//   Ports
//     clk        clock
//     rst        synchronous, active-high reset
//     bus        if_fetch_unit_if.master (memory, predictor, redirect, ID)
//     fsm_state  debug view of the internal state (0 FETCH, 1 DECODE,
//                2 HOLD, 3 FLUSH)
//
//   Optional feature
//     STATIC_JAL_EN  when defined, JAL is resolved in fetch (pc + J_imm,
//                    predicted taken); otherwise JAL is fetched sequentially
//                    and EX redirects to the target.
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          PRED_IDX_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   bus,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_HOLD   = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] next_pc_q, next_pc_n;
    logic        pred_q, pred_n;

    // Decode helpers, only meaningful once all four bytes are in inst_q.
    logic [6:0]  opcode;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [31:0] pc_plus4;

    assign opcode   = inst_q[6:0];
    assign b_imm    = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign j_imm    = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            byte_cnt  <= 2'd0;
            inst_q    <= 32'h0;
            next_pc_q <= 32'h0;
            pred_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            byte_cnt  <= byte_cnt_n;
            inst_q    <= inst_n;
            next_pc_q <= next_pc_n;
            pred_q    <= pred_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        byte_cnt_n = byte_cnt;
        inst_n     = inst_q;
        next_pc_n  = next_pc_q;
        pred_n     = pred_q;

        case (state)
            S_FETCH: begin
                if (bus.mem_valid) begin
                    inst_n[{byte_cnt, 3'b000} +: 8] = bus.mem_data;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_n = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                // pred_idx has been pc-derived since the fetch started, so
                // the predictor output is settled here.
                next_pc_n = pc_plus4;
                pred_n    = 1'b0;
                if (opcode == OP_BRANCH) begin
                    pred_n = bus.pred_taken;
                    if (bus.pred_taken) begin
                        next_pc_n = pc + b_imm;
                    end
                end
`ifdef STATIC_JAL_EN
                else if (opcode == OP_JAL) begin
                    next_pc_n = pc + j_imm;
                    pred_n    = 1'b1;
                end
`endif
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (!bus.stall) begin
                    pc_n       = next_pc_q;
                    byte_cnt_n = 2'd0;
                    state_n    = S_FETCH;
                end
            end
            S_FLUSH: begin
                state_n = S_FETCH;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        // Redirect wins over everything except reset; any byte or transfer
        // in this cycle is dropped by restoring inst_q and overriding pc.
        if (bus.redirect) begin
            pc_n       = bus.redirect_pc;
            byte_cnt_n = 2'd0;
            inst_n     = inst_q;
            state_n    = S_FLUSH;
        end
    end

    // Outputs: forced to 0 while rst is asserted, since the registers only
    // take their reset values at the end of that cycle.
    always_comb begin
        bus.mem_req         = 1'b0;
        bus.mem_addr        = 32'h0;
        bus.pred_idx        = '0;
        bus.inst_valid      = 1'b0;
        bus.inst            = 32'h0;
        bus.inst_pc         = 32'h0;
        bus.inst_pred_taken = 1'b0;
        if (!rst) begin
            bus.pred_idx = pc[PRED_IDX_W+1:2];
            if (state == S_FETCH) begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc + {30'h0, byte_cnt};
            end
            if (state == S_HOLD) begin
                bus.inst_valid      = 1'b1;
                bus.inst            = inst_q;
                bus.inst_pc         = pc;
                bus.inst_pred_taken = pred_q;
            end
        end
    end

    // j_imm is only consumed when STATIC_JAL_EN is defined.
    logic unused_ok;
    assign unused_ok = ^j_imm;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;

    if_fetch_unit_if #(.PRED_IDX_W(8)) bus_if ();

    if_fetch_unit #(.RESET_PC(32'h0), .PRED_IDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory / predictor models ----------------
    logic [7:0] mem [0:511];
    logic       pred_tbl [0:255];
    logic       mem_en = 1'b1;

    assign bus_if.mem_valid  = bus_if.mem_req && mem_en;
    assign bus_if.mem_data   = mem[bus_if.mem_addr[8:0]];
    assign bus_if.pred_taken = pred_tbl[bus_if.pred_idx];

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];
    logic        log_en = 1'b0;

    always @(negedge clk) begin
        #2;
        if (log_en && !rst && bus_if.mem_req && bus_if.mem_valid && !bus_if.redirect)
            addr_log.push_back(bus_if.mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic put_word(input int addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[addr + i] = w[8*i +: 8];
    endtask

    task automatic wait_hold(input string tag, output int cyc);
        cyc = 0;
        while (!bus_if.inst_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, {31'h0, bus_if.inst_valid}, 32'h1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = target;
        @(negedge clk);
        bus_if.redirect    = 1'b0;
        check("flush_req",   {31'h0, bus_if.mem_req},    32'h0);
        check("flush_valid", {31'h0, bus_if.inst_valid}, 32'h0);
    endtask

    // Release one transfer and check where the following fetch begins.
    task automatic release_and_check(input string tag, input logic [31:0] exp_next);
        bus_if.stall = 1'b0;
        @(negedge clk);
        bus_if.stall = 1'b1;
        check({tag, "_next_req"},  {31'h0, bus_if.mem_req}, 32'h1);
        check({tag, "_next_addr"}, bus_if.mem_addr, exp_next);
    endtask

    task automatic run_one(input string tag, input logic [31:0] start_pc,
                           input logic [31:0] exp_inst, input logic exp_pred,
                           input logic [31:0] exp_next);
        int cyc;
        do_redirect(start_pc);
        @(negedge clk);
        check({tag, "_pred_idx"}, {24'h0, bus_if.pred_idx}, {24'h0, start_pc[9:2]});
        wait_hold(tag, cyc);
        check({tag, "_inst"}, bus_if.inst, exp_inst);
        check({tag, "_pc"},   bus_if.inst_pc, start_pc);
        check({tag, "_pred"}, {31'h0, bus_if.inst_pred_taken}, {31'h0, exp_pred});
        release_and_check(tag, exp_next);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        logic [31:0] s_inst, s_pc, s_pred, e_addr;

        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'h0;
        bus_if.stall       = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) pred_tbl[i] = 1'b0;

        put_word(32'h000, 32'h00100513);   // addi a0,x0,1
        put_word(32'h008, 32'h040000EF);   // jal  +0x40
        put_word(32'h010, 32'h00000463);   // beq  +8
        put_word(32'h020, 32'hFE0008E3);   // beq  -16
        put_word(32'h040, 32'hDDCCBBAA);   // aborted fetch source
        put_word(32'h100, 32'h12345033);   // redirect target

        // Reset: every output 0 while rst is high.
        repeat (2) @(negedge clk);
        check("rst_mem_req",  {31'h0, bus_if.mem_req},    32'h0);
        check("rst_valid",    {31'h0, bus_if.inst_valid}, 32'h0);
        check("rst_pred_idx", {24'h0, bus_if.pred_idx},   32'h0);
        check("rst_addr",     bus_if.mem_addr,            32'h0);

        // Test 1: first fetch from RESET_PC, byte order and latency.
        log_en = 1'b1;
        rst    = 1'b0;
        wait_hold("t1", cyc);
        log_en = 1'b0;
        check("t1_latency", cyc, 32'd5);
        exp_q = '{32'h0, 32'h1, 32'h2, 32'h3};
        check("t1_nbytes", addr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && addr_log.size() > 0)
            check("t1_addr", addr_log.pop_front(), exp_q.pop_front());
        check("t1_inst", bus_if.inst, 32'h00100513);
        check("t1_pc",   bus_if.inst_pc, 32'h0);
        check("t1_pred", {31'h0, bus_if.inst_pred_taken}, 32'h0);

        // Test 4: stall holds the offer stable with no memory traffic.
        s_inst = bus_if.inst;
        s_pc   = bus_if.inst_pc;
        s_pred = {31'h0, bus_if.inst_pred_taken};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_valid", {31'h0, bus_if.inst_valid}, 32'h1);
            check("t4_inst",  bus_if.inst, s_inst);
            check("t4_pc",    bus_if.inst_pc, s_pc);
            check("t4_pred",  {31'h0, bus_if.inst_pred_taken}, s_pred);
            check("t4_req",   {31'h0, bus_if.mem_req}, 32'h0);
        end
        release_and_check("t1", 32'h4);

        // Test 2: beq +8, predicted taken then not taken.
        pred_tbl[4] = 1'b1;
        run_one("t2_taken", 32'h10, 32'h00000463, 1'b1, 32'h18);
        pred_tbl[4] = 1'b0;
        run_one("t2_ntaken", 32'h10, 32'h00000463, 1'b0, 32'h14);

        // Test 3: backward branch wraps below its own PC.
        pred_tbl[8] = 1'b1;
        run_one("t3", 32'h20, 32'hFE0008E3, 1'b1, 32'h10);

        // Test 6: JAL handling depends on the build option.
`ifdef STATIC_JAL_EN
        run_one("t6", 32'h08, 32'h040000EF, 1'b1, 32'h48);
`else
        run_one("t6", 32'h08, 32'h040000EF, 1'b0, 32'h0C);
`endif

        // Test 5: redirect with byte 2 outstanding.
        do_redirect(32'h40);
        @(negedge clk);                    // byte 0 offered
        @(negedge clk);                    // byte 1 offered
        @(negedge clk);                    // byte 2 offered
        mem_en = 1'b0;
        check("t5_outstanding", bus_if.mem_addr, 32'h42);
        @(negedge clk);
        check("t5_still_req", {31'h0, bus_if.mem_req}, 32'h1);
        mem_en = 1'b1;                     // byte returns in the redirect cycle
        do_redirect(32'h100);
        @(negedge clk);
        check("t5_req",  {31'h0, bus_if.mem_req}, 32'h1);
        check("t5_addr", bus_if.mem_addr, 32'h100);
        wait_hold("t5", cyc);
        check("t5_inst", bus_if.inst, 32'h12345033);
        check("t5_pc",   bus_if.inst_pc, 32'h100);
        release_and_check("t5", 32'h104);

        // Reset mid-fetch: restart at RESET_PC with no flush cycle.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'h0, bus_if.mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_req_after", {31'h0, bus_if.mem_req}, 32'h1);
        check("mid_rst_state",     {30'h0, fsm_state}, 32'h0);
        e_addr = 32'h0;
        check("mid_rst_addr", bus_if.mem_addr, e_addr);
        wait_hold("mid_rst", cyc);
        check("mid_rst_latency", cyc, 32'd5);
        check("mid_rst_inst", bus_if.inst, 32'h00100513);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: keeps the run bounded even if a wait loop misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
